spi_response_tx: RTL

SPI_RESPONSE_TX -- requirements
Module: spi_response_tx

---
 rtl/spi_response_tx_pkg.sv | 13 +
 rtl/spi_response_tx_resp_fifo.sv | 71 +++++++
 rtl/spi_response_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_response_tx_pkg.sv
// Shared types and constants for the SPI response transmitter.
package spi_response_tx_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DEFAULT_IDLE_BYTE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/spi_response_tx_resp_fifo.sv
// Response byte buffer: power-of-two circular FIFO with combinational head read.
// A push while full is only accepted when a pop happens in the same cycle.
module resp_fifo
    import spi_response_tx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [BYTE_W-1:0]       push_data,
    input  logic                    pop,
    output logic [BYTE_W-1:0]       head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push_ok, pop_ok;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spi_response_tx.sv
// SPI mode-0 slave response transmitter: buffers response bytes and shifts them out MSB first.
// Optional build macro SPI_RESP_LEN_PREFIX_EN sends the buffered byte count as the first byte.
module spi_response_tx
    import spi_response_tx_pkg::*;
#(
    parameter int                FIFO_DEPTH  = 16,
    parameter logic [BYTE_W-1:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                         sysClk,
    input  logic                         reset,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_in_valid,
    input  logic                         spi_sclk,
    input  logic                         spi_cs_n,
    input  logic                         clear_overflow,
    output logic                         spi_miso,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic                         tx_byte_done,
    output logic                         overflow_flag
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_prev_q, cs_prev_q;
    logic [SW-1:0]          settle_q, settle_d;
    logic                   armed_q, armed_d;
    logic                   sclk_s, cs_s, settle_done;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    tx_state_e              state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   last_bit_q, last_bit_d;
    logic [BYTE_W-1:0]      shreg_q, shreg_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;
    logic                   pop_req;
`ifdef SPI_RESP_LEN_PREFIX_EN
    logic                   first_q, first_d;
`endif

    logic [BYTE_W-1:0]      head_w;
    logic                   full_w, empty_w;
    logic [CW-1:0]          count_w;

`ifdef SPI_RESP_LEN_PREFIX_EN
    function automatic logic [BYTE_W-1:0] len_to_byte(input logic [CW-1:0] cnt);
        int unsigned v;
        v = 32'(cnt);
        if (v > 32'd255) begin
            return 8'hFF;
        end
        return v[BYTE_W-1:0];
    endfunction
`endif

    resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sysClk),
        .rst       (reset),
        .push      (byte_in_valid),
        .push_data (byte_in),
        .pop       (pop_req),
        .head_data (head_w),
        .full      (full_w),
        .empty     (empty_w),
        .count     (count_w)
    );

    // After reset the synchronizers hold cs high until the real pin value has flushed
    // through; a cs that was already low must not be mistaken for a fresh falling edge.
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign settle_done = (settle_q == SW'(SYNC_STAGES));
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign cs_rise     = cs_s & ~cs_prev_q;
    assign cs_fall     = armed_q & ~cs_s & cs_prev_q;

    always_comb begin
        sclk_sync_d    = sclk_sync_q << 1;
        sclk_sync_d[0] = spi_sclk;
        cs_sync_d      = cs_sync_q << 1;
        cs_sync_d[0]   = spi_cs_n;
        settle_d       = settle_done ? settle_q : settle_q + SW'(1);
        armed_d        = armed_q | (settle_done & cs_s);
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        shreg_d    = shreg_q;
        done_d     = 1'b0;
        pop_req    = 1'b0;
`ifdef SPI_RESP_LEN_PREFIX_EN
        first_d    = first_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_LOAD;
`ifdef SPI_RESP_LEN_PREFIX_EN
                    first_d = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
`ifdef SPI_RESP_LEN_PREFIX_EN
                if (first_q) begin
                    shreg_d = len_to_byte(count_w);
                    first_d = 1'b0;
                end else
`endif
                if (!empty_w) begin
                    shreg_d = head_w;
                    pop_req = 1'b1;
                end else begin
                    shreg_d = IDLE_BYTE;
                end
                bit_cnt_d  = 3'd0;
                last_bit_d = 1'b0;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Host samples on rising edges; the next bit is presented after the falling edge.
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        last_bit_d = 1'b1;
                        done_d     = 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (last_bit_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cs_rise) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            last_bit_d = 1'b0;
            pop_req    = 1'b0;
        end
    end

    always_comb begin
        overflow_d = (byte_in_valid & full_w & ~pop_req) | (overflow_q & ~clear_overflow);
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            last_bit_q  <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef SPI_RESP_LEN_PREFIX_EN
            first_q     <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            last_bit_q  <= last_bit_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
`ifdef SPI_RESP_LEN_PREFIX_EN
            first_q     <= first_d;
`endif
        end
    end

    always_ff @(posedge sysClk) begin
        shreg_q <= shreg_d;
    end

    assign spi_miso      = (state_q == ST_SHIFT) & shreg_q[BYTE_W-1];
    assign tx_byte_done  = done_q;
    assign overflow_flag = overflow_q;
    assign fifo_count    = count_w;
    assign fifo_full     = full_w;
    assign fifo_empty    = empty_w;

endmodule
